// File: rtl/instr_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_load_ctrl
//  Purpose  : Loads up to eight instruction bytes from switches, one byte per
//             debounced button press (either edge), then hands the image to a
//             hazard checker and, once acknowledged, enables execution.
//  Ports    : clk          - single clock, rising edge
//             rst          - asynchronous active-high reset
//             input_val    - instruction byte from the switches
//             but_inp      - raw, asynchronous, bouncing button
//             reload       - synchronous request to discard program and reload
//             chk_ack      - acknowledge from the hazard checker
//             instrMemBits - instruction image, slot k at bits [8k+7:8k]
//             load_count   - number of stored instructions (0-8)
//             chk_req      - request to the hazard checker
//             run_en       - pipeline execution enable
//             state        - FSM state: LOAD=00, CHECK=01, RUN=10
//  Revision : 1.0 - initial release
// ============================================================================
module instr_load_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  input_val,
   input  logic        but_inp,
   input  logic        reload,
   input  logic        chk_ack,
   output logic [63:0] instrMemBits,
   output logic [3:0]  load_count,
   output logic        chk_req,
   output logic        run_en,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'b00,
      ST_CHECK = 2'b01,
      ST_RUN   = 2'b10
   } state_t;

   localparam logic [7:0] DB_LIMIT   = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0] TERMINATOR = 8'hFF;

   // ---------------------------------------------------------------------
   // Button synchronizer and debouncer
   // ---------------------------------------------------------------------
   logic       sync1_q, sync2_q;
   logic       level_q, level_d;
   logic [7:0] cnt_q,   cnt_d;
   logic       press_q, press_d;

   // The count only advances while the synchronized level disagrees with
   // the accepted one; any agreeing cycle restarts the interval.
   always_comb begin
      level_d = level_q;
      cnt_d   = 8'd0;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q + 8'd1 == DB_LIMIT) begin
            level_d = sync2_q;
            press_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // Debouncer runs in every state so no stale press is pending when the
   // FSM returns to LOAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= 8'd0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= but_inp;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   // ---------------------------------------------------------------------
   // Load / check / run FSM with registered outputs
   // ---------------------------------------------------------------------
   state_t      state_q;
   logic [63:0] mem_q;
   logic [3:0]  load_cnt_q;
   logic        chk_req_q;
   logic        run_en_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         mem_q      <= 64'h0;
         load_cnt_q <= 4'd0;
         chk_req_q  <= 1'b0;
         run_en_q   <= 1'b0;
      end else if (reload) begin
         // Reload outranks any simultaneous press or acknowledge.
         state_q    <= ST_LOAD;
         mem_q      <= 64'h0;
         load_cnt_q <= 4'd0;
         chk_req_q  <= 1'b0;
         run_en_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (press_q) begin
                  if (input_val == TERMINATOR) begin
                     state_q   <= ST_CHECK;
                     chk_req_q <= 1'b1;
                  end else begin
                     // load_cnt_q is below 8 whenever LOAD is active.
                     mem_q[{load_cnt_q[2:0], 3'b000} +: 8] <= input_val;
                     load_cnt_q <= load_cnt_q + 4'd1;
                     if (load_cnt_q == 4'd7) begin
                        state_q   <= ST_CHECK;
                        chk_req_q <= 1'b1;
                     end
                  end
               end
            end
            ST_CHECK: begin
               if (chk_ack) begin
                  state_q   <= ST_RUN;
                  chk_req_q <= 1'b0;
                  run_en_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               // Held until reload or reset.
            end
            default: begin
               state_q   <= ST_LOAD;
               chk_req_q <= 1'b0;
               run_en_q  <= 1'b0;
            end
         endcase
      end
   end

   assign instrMemBits = mem_q;
   assign load_count   = load_cnt_q;
   assign chk_req      = chk_req_q;
   assign run_en       = run_en_q;
   assign state        = state_q;

endmodule
`default_nettype wire

// File: doc/instr_load_ctrl.md
INSTR_LOAD_CTRL -- requirements
Module: instr_load_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the cycles a synchronized button level must be stable before it is accepted (legal range 1-255).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port input_val, input, 8 bits, the instruction byte from the switches.
REQ-005 The block SHALL have port but_inp, input, 1 bit, the raw, asynchronous, bouncing button; each accepted level change (either direction) is one "press".
REQ-006 The block SHALL have port reload, input, 1 bit, a synchronous request to discard the program and restart loading.
REQ-007 The block SHALL have port chk_ack, input, 1 bit, the acknowledge from the hazard checker.
REQ-008 The block SHALL have port instrMemBits, output, 64 bits, the instruction image; slot k occupies bits [8k+7:8k].
REQ-009 The block SHALL have port load_count, output, 4 bits, the number of stored instructions (0-8).
REQ-010 The block SHALL have port chk_req, output, 1 bit, the request to the hazard checker to evaluate instrMemBits.
REQ-011 The block SHALL have port run_en, output, 1 bit, the enable for pipeline execution.
REQ-012 The block SHALL have port state, output, 2 bits, the current FSM state: LOAD=00, CHECK=01, RUN=10.

Function
REQ-013 The block SHALL pass but_inp through a two-flop synchronizer before any use.
REQ-014 The debouncer SHALL hold an accepted level and count the consecutive cycles in which the synchronized level differs from it; the count clears on any cycle where they match.
REQ-015 When the count reaches DEBOUNCE_CYCLES, the debouncer SHALL update the accepted level and raise a one-cycle press pulse.
REQ-016 The press pulse SHALL occur 2+DEBOUNCE_CYCLES cycles after a clean but_inp change; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no pulse.
REQ-017 In LOAD, a press pulse SHALL sample input_val in that same cycle.
REQ-018 In LOAD, if the sampled value is not 8'hFF, the block SHALL write it to slot load_count and increment load_count; both outputs are visible the next cycle.
REQ-019 In LOAD, if the sampled value is 8'hFF (terminator), the block SHALL store nothing, leave load_count unchanged and go to CHECK.
REQ-020 In LOAD, a store that makes load_count equal 8 SHALL move the FSM to CHECK in the same edge; no further bytes are stored.
REQ-021 The block SHALL hold unwritten slots at 8'h00 (NOP).
REQ-022 A terminator received with load_count=0 SHALL still go to CHECK, with an all-zero image.
REQ-023 In CHECK, chk_req SHALL be 1 and SHALL stay high until chk_ack is sampled high; the FSM then goes to RUN and chk_req drops on the next cycle.
REQ-024 In CHECK, instrMemBits SHALL be stable.
REQ-025 In RUN, run_en SHALL be 1; run_en SHALL be 0 in every other state.
REQ-026 Presses in CHECK or RUN SHALL be ignored, but the debouncer SHALL keep tracking so that no stale pulse fires after a return to LOAD.
REQ-027 reload=1 in any state SHALL, on the next edge, clear instrMemBits and load_count, drop chk_req and run_en, and enter LOAD.
REQ-028 reload SHALL take priority over a simultaneous press or chk_ack.
REQ-029 chk_ack received outside CHECK SHALL be ignored.

Reset
REQ-030 On rst=1, regardless of clk, the block SHALL set state=LOAD, instrMemBits=64'h0, load_count=0, chk_req=0 and run_en=0.
REQ-031 On rst=1, the block SHALL set the synchronizer flops and the accepted level to 0 and the debounce count to 0.
REQ-032 Reset asserted mid-operation (any state, mid-debounce) SHALL abandon the operation with no partial store.
REQ-033 After reset release, the first press SHALL require but_inp to differ from 0 for the full debounce interval.

Verification
REQ-034 With DEBOUNCE_CYCLES=4, after reset, the bench SHALL toggle but_inp with input_val=8'h88, 8'h89, 8'h8A, 8'h8C, 8'h90, 8'hA8, 8'h89, 8'hFF, holding each for 20 cycles -> load_count=7, slot 0=8'h88, slot 6=8'h89, slot 7=8'h00, state=CHECK, chk_req=1.
REQ-035 The bench SHALL toggle with eight non-FF bytes 8'h01..8'h08 -> instrMemBits=64'h0807060504030201, FSM in CHECK after the 8th press, and a 9th press leaves the image unchanged.
REQ-036 The bench SHALL apply a 3-cycle but_inp glitch with input_val=8'h55 -> no store, load_count=0; the bench SHALL check that a clean toggle lands the store exactly 7 cycles after the but_inp edge (2 sync + 4 debounce + 1).
REQ-037 In CHECK, the bench SHALL hold chk_ack=0 for 10 cycles -> chk_req stays 1, run_en=0; the bench SHALL then pulse chk_ack for 1 cycle -> RUN next cycle, run_en=1, chk_req=0.
REQ-038 In RUN, the bench SHALL assert reload together with a press -> next cycle state=LOAD, image 0, load_count=0, no byte stored.
REQ-039 The bench SHALL assert rst asynchronously mid-debounce, with load_count=3 -> all outputs at reset values immediately; the bench SHALL check that no press fires after release until a full-interval toggle.
